// File: rtl/cs_adder_seq_ctrl.sv
// cs_adder_seq_ctrl: multi-cycle WIDTH-bit adder built around one 4-bit
// carry-select slice. Each clock the slice adds one nibble of the captured
// operands. Its carry-out is registered and becomes the next nibble's carry-in.
// The input and output sides each use a valid/ready handshake.
module cs_adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] sum0;
  logic [3:0] sum1;
  logic       rc0;
  logic       rc1;
  logic [3:0] slice_sum;
  logic       slice_cout;

  // Carry-select slice: two ripple chains (carry-in 0 and 1), then select on the registered carry
  always_comb begin
    nib_a = op_a[4*idx +: 4];
    nib_b = op_b[4*idx +: 4];
    sum0  = 4'd0;
    sum1  = 4'd0;
    rc0   = 1'b0;
    rc1   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum0[i] = nib_a[i] ^ nib_b[i] ^ rc0;
      rc0     = (nib_a[i] & nib_b[i]) | (nib_a[i] & rc0) | (nib_b[i] & rc0);
      sum1[i] = nib_a[i] ^ nib_b[i] ^ rc1;
      rc1     = (nib_a[i] & nib_b[i]) | (nib_a[i] & rc1) | (nib_b[i] & rc1);
    end
    slice_sum  = carry ? sum1 : sum0;
    slice_cout = carry ? rc1  : rc0;
  end

  // Sequencer FSM with registered handshake outputs; one nibble processed per RUN edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= a;
            op_b     <= b;
            carry    <= cin;
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_sum;
          carry           <= slice_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            cout      <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_adder_seq_ctrl.sv
// tb_cs_adder_seq_ctrl: directed bench for the nibble-serial carry-select adder,
// covering a 16-bit instance and an 8-bit instance.
module tb_cs_adder_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  sum8;
  logic        cout8;
  logic        busy8;

  int errors = 0;
  int checks = 0;

  cs_adder_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  cs_adder_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 unit past it before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand set, take the accept edge, then measure edges until out_valid
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input string tag);
    int lat;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    check({tag, "_inready_after_accept"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd4);
  endtask

  // Compare the held result, then complete the output handshake and confirm return to IDLE
  task automatic checkOutput(input logic [15:0] es, input logic ec, input string tag);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_inready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_outvalid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Directed test sequence
  initial begin
    int lat8;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    tick();
    tick();
    check("rst_inready", {31'd0, in_ready}, 32'd1);
    check("rst_outvalid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();

    // Wrap-around: all-ones + 1
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, "t1");
    checkOutput(16'h0000, 1'b1, "t1");

    // Plain add with carry-in
    applyStimulus(16'h1234, 16'h4321, 1'b1, "t2");
    checkOutput(16'h5556, 1'b0, "t2");

    // Stall in DONE for 5 clocks while in_valid pulses with other operands
    applyStimulus(16'h00FF, 16'h0F01, 1'b0, "t3");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      tick();
      check("t3_hold_outvalid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_sum", {16'd0, sum}, 32'h1000);
      check("t3_hold_cout", {31'd0, cout}, 32'd0);
      check("t3_hold_inready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    checkOutput(16'h1000, 1'b0, "t3");

    // Reset mid-operation after two nibbles have been processed
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_inready", {31'd0, in_ready}, 32'd1);
    check("t4_rst_outvalid", {31'd0, out_valid}, 32'd0);
    check("t4_rst_sum", {16'd0, sum}, 32'd0);
    check("t4_rst_cout", {31'd0, cout}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(16'h1111, 16'h2222, 1'b0, "t4b");
    checkOutput(16'h3333, 1'b0, "t4b");

    // Back-to-back with in_valid and out_ready held high: accepts 6 clocks apart
    a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("t5_accept1_busy", {31'd0, busy}, 32'd1);
    a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 4 || t == 10) begin
        check("t5_outvalid", {31'd0, out_valid}, 32'd1);
        check("t5_sum", {16'd0, sum}, 32'h0000);
        check("t5_cout", {31'd0, cout}, 32'd1);
      end else if (t == 5) begin
        check("t5_idle_inready", {31'd0, in_ready}, 32'd1);
        check("t5_idle_outvalid", {31'd0, out_valid}, 32'd0);
      end else if (t == 6) begin
        check("t5_accept2_busy", {31'd0, busy}, 32'd1);
        check("t5_accept2_inready", {31'd0, in_ready}, 32'd0);
      end else begin
        check("t5_outvalid_low", {31'd0, out_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("t5_final_idle", {31'd0, in_ready}, 32'd1);

    // 8-bit instance: two-nibble latency
    a8 = 8'hA5; b8 = 8'h5B; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat8 = 0;
    while (!out_valid8 && lat8 < 20) begin
      tick();
      lat8++;
    end
    check("t6_latency", lat8, 32'd2);
    check("t6_sum", {24'd0, sum8}, 32'h00);
    check("t6_cout", {31'd0, cout8}, 32'd1);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("t6_idle_inready", {31'd0, in_ready8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
